ifu_fetch: RTL
==============

# ifu_fetch

Instruction fetch unit for the RV32 core. Generates sequential word addresses into the 2048×32 single-port BSRAM instruction memory (1-cycle synchronous read) and absorbs its read latency. Delivers `{pc, instr}` pairs to decode over a valid/ready handshake at one instruction per cycle. Accepts redirects (branch/jump/trap target) that flush all in-flight and buffered fetches.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `ADDR_W`, 11: instruction memory word-address width; memory spans 2^(ADDR_W+2) bytes.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `redirect`  in  1  load new fetch PC, flush pipeline.
- `redirect_pc`  in  32  target; bits [1:0] ignored (forced 0).
- `if_valid`  out  1  output entry valid.
- `if_ready`  in  1  decode accepts entry.
- `if_pc`  out  32  PC of output instruction.
- `if_instr`  out  32  instruction word.
- `imem_ce`  out  1  memory clock enable, high only on issue cycles.
- `imem_oce`  out  1  tied 1.
- `imem_reset`  out  1  = `reset`.
- `imem_wre`  out  1  tied 0.
- `imem_ad`  out  ADDR_W  = `pc[ADDR_W+1:2]`.
- `imem_din`  out  32  tied 0.
- `imem_dout`  in  32  memory read data, valid the cycle after issue.

## Operation
- State: `pc` (next fetch address), `inflight` + `inflight_pc` (issued last cycle), 2-entry FIFO of `{pc, instr}`, `count` (0..2).
- `pop = if_valid & if_ready`; `if_valid = (count != 0)`; `if_pc`/`if_instr` = FIFO head (registered, not combinational from `imem_dout`).
- Issue condition: `!reset & !redirect & (count - pop + inflight) <= 1`. On issue: `imem_ce=1`, `inflight<=1`, `inflight_pc<=pc`, `pc<=pc+4`. Otherwise `imem_ce=0`, `inflight<=0`.
- Push: if `inflight & !redirect`, push `{inflight_pc, imem_dout}` into FIFO. Push and pop in the same cycle are both honoured. The issue rule guarantees a push never finds the FIFO full; overflow is a design error, flagged by bench assertion.
- Redirect (priority over issue/push): `pc<=redirect_pc & ~3`, `inflight<=0`, FIFO cleared, `count<=0`. A pop in the same cycle completes normally (decode owns that entry). Back-to-back redirects: last one wins.
- Reset (priority over everything): `pc<=RESET_PC`, `inflight<=0`, `count<=0`.
- Arithmetic: `pc` is 32-bit, wraps modulo 2^32. `imem_ad` aliases modulo memory size; no out-of-range detection.

## Timing
- Reset values: `if_valid=0`, `imem_ce=0`; `if_pc`/`if_instr` hold FIFO content (don't-care while `if_valid=0`). `imem_oce=1`, `imem_wre=0`.
- First cycle with `reset` low = cycle 0: issue `RESET_PC`. Cycle 1: push. Cycle 2: `if_valid=1`, `if_pc=RESET_PC`.
- Redirect asserted in cycle r: `if_valid=0` from r+1; issue at r+1; target valid at r+3.
- With `if_ready=1` continuously, steady state is one instruction per cycle (count=1, inflight=1).
- Backpressure: FIFO fills to 2, issue stops, `imem_ce=0`. After `if_ready` returns, the FIFO drains; the next issue occurs in the same cycle as the first pop.

## Test plan
- Reset release, `RESET_PC=0`, `if_ready=1`, bench memory `mem[i]=32'hA500_0000|i` -> cycle 2 onward `if_pc`=0,4,8,… each cycle with `if_instr`=A5000000, A5000001, …; no gaps.
- Stream, then `if_ready=0` for 5 cycles -> `if_valid` and head stable, `count`=2, `imem_ce`=0 after fill; release -> sequence resumes with no drop or duplicate.
- Redirect to 0x40 mid-stream -> no stale PC after the redirect cycle; `if_pc`=0x40 valid exactly 3 cycles after redirect, then 0x44.
- Redirect to 0x43, then 0x80 on the next cycle -> only 0x80 sequence emitted; 0x40 never appears; pop coincident with the first redirect is delivered once.
- Redirect to 0x1FFC -> `imem_ad`=0x7FF, then 0x000; `if_pc`=0x1FFC, 0x2000 with `if_instr`=mem[2047], mem[0].
- Assert `reset` for 1 cycle with FIFO full and a fetch in flight -> `if_valid=0` next cycle; restart at `RESET_PC`, first valid 2 cycles after release.

Source files
------------

// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Sequential instruction fetch with redirect flush and a 2-entry
//            skid FIFO that hides the 1-cycle synchronous BSRAM read.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              imem_ce,
  output logic              imem_oce,
  output logic              imem_reset,
  output logic              imem_wre,
  output logic [ADDR_W-1:0] imem_ad,
  output logic [31:0]       imem_din,
  input  logic [31:0]       imem_dout
);

  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic        r_inflight;
  logic [1:0]  r_count;
  logic [63:0] r_head;
  logic [63:0] r_tail;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_occ;
  logic [63:0] w_new;

  assign if_valid = (r_count != 2'd0);
  assign if_pc    = r_head[63:32];
  assign if_instr = r_head[31:0];

  assign w_pop  = if_valid & if_ready;
  assign w_push = r_inflight & ~redirect;
  assign w_new  = {r_inflight_pc, imem_dout};

  // Occupancy after this cycle's pop, counting the read still in the BSRAM.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = ~reset & ~redirect & (w_occ <= 3'd1);

  assign imem_ce    = w_issue;
  assign imem_oce   = 1'b1;
  assign imem_reset = reset;
  assign imem_wre   = 1'b0;
  assign imem_ad    = r_pc[ADDR_W+1:2];
  assign imem_din   = 32'h0000_0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
    end else if (redirect) begin
      r_pc       <= redirect_pc & ~32'd3;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 32'd4;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Data path carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (!reset && !redirect) begin
      case ({w_push, w_pop})
        2'b01: r_head <= r_tail;
        2'b10: begin
          if (r_count == 2'd0) r_head <= w_new;
          else                 r_tail <= w_new;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= w_new;
          end else begin
            r_head <= r_tail;
            r_tail <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
